// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM encoding,
// block geometry and the padding marker byte.
package sha256_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int LEN_BITS    = 64;

  localparam logic [7:0] PAD_MARKER = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAD   = 3'd2,
    S_START = 3'd3,
    S_SEND  = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } pad_state_t;

  // Word holding only the marker in its most significant byte.
  function automatic logic [31:0] marker_word();
    return {PAD_MARKER, 24'h000000};
  endfunction

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational padding helper: merges the 0x80 marker into the last
// message word, reports which buffer words must be zero-filled and
// whether the 64-bit length still fits in the current block.
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  logic [31:0]            last_word,
  input  logic [2:0]             last_bytes,
  input  logic [3:0]             last_idx,
  output logic [31:0]            merged_word,
  output logic [BLOCK_WORDS-1:0] zero_mask,
  output logic                   marker_next,
  output logic                   marker_pending,
  output logic                   fits_len
);

  logic [4:0] marker_idx;

  // Marker placement, zero-fill mask and length-fit decision.
  always_comb begin
    merged_word = last_word;
    case (last_bytes)
      3'd0:    merged_word = marker_word();
      3'd1:    merged_word = {last_word[31:24], PAD_MARKER, 16'h0000};
      3'd2:    merged_word = {last_word[31:16], PAD_MARKER, 8'h00};
      3'd3:    merged_word = {last_word[31:8], PAD_MARKER};
      default: merged_word = last_word;
    endcase

    // A full last word pushes the marker into the following word,
    // which may fall off the end of the block.
    marker_next    = (last_bytes >= 3'd4);
    marker_idx     = {1'b0, last_idx} + {4'd0, marker_next};
    marker_pending = marker_idx[4];
    fits_len       = (marker_idx <= 5'd13);

    for (int i = 0; i < BLOCK_WORDS; i++) begin
      zero_mask[i] = (i > int'(last_idx));
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects big-endian message words into a
// 512-bit block buffer, applies marker/zero/length padding and feeds
// each block to the SHA-256 controller one word per request.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        in_ready,
  output logic        sha_start,
  output logic        new_msg_n,
  input  logic        word_req,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        hash_done,
  output logic        msg_done
);

  pad_state_t           state;
  logic [31:0]          blk_buf [BLOCK_WORDS];
  logic [3:0]           idx;
  logic [LEN_BITS-1:0]  byte_cnt;
  logic [LEN_BITS-1:0]  bit_len;
  logic [3:0]           last_idx;
  logic [2:0]           last_bytes;
  logic                 first_blk;
  logic                 final_blk;
  logic                 need_extra;
  logic                 pending_80;

  logic [31:0]            fill_word;
  logic [BLOCK_WORDS-1:0] zero_mask;
  logic                   marker_next;
  logic                   marker_pending;
  logic                   fits_len;
  logic                   accept;

  sha256_pad_fill u_fill (
    .last_word      (blk_buf[last_idx]),
    .last_bytes     (last_bytes),
    .last_idx       (last_idx),
    .merged_word    (fill_word),
    .zero_mask      (zero_mask),
    .marker_next    (marker_next),
    .marker_pending (marker_pending),
    .fits_len       (fits_len)
  );

  assign bit_len    = {byte_cnt[LEN_BITS-4:0], 3'b000};
  assign in_ready   = (state == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign word_valid = (state == S_SEND) && word_req;
  assign word_data  = word_valid ? blk_buf[idx] : 32'h0000_0000;

  // Block-assembly and handshake FSM with registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      last_idx   <= '0;
      last_bytes <= '0;
      first_blk  <= 1'b0;
      final_blk  <= 1'b0;
      need_extra <= 1'b0;
      pending_80 <= 1'b0;
      sha_start  <= 1'b0;
      new_msg_n  <= 1'b1;
      msg_done   <= 1'b0;
    end else begin
      sha_start <= 1'b0;
      new_msg_n <= 1'b1;
      msg_done  <= 1'b0;

      case (state)
        S_IDLE: begin
          for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
          idx        <= '0;
          byte_cnt   <= '0;
          final_blk  <= 1'b0;
          need_extra <= 1'b0;
          pending_80 <= 1'b0;
          if (in_valid) begin
            first_blk <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            blk_buf[idx] <= in_data;
            byte_cnt     <= byte_cnt + LEN_BITS'(in_bytes);
            idx          <= idx + 4'd1;
            if (in_last) begin
              last_idx   <= idx;
              last_bytes <= in_bytes;
              state      <= S_PAD;
            end else if (idx == 4'd15) begin
              sha_start <= 1'b1;
              new_msg_n <= ~first_blk;
              state     <= S_START;
            end
          end
        end

        S_PAD: begin
          // Later writes override earlier ones: zero fill, then the
          // merged last word, then the spilled marker, then length.
          for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (zero_mask[i]) blk_buf[i] <= '0;
          end
          blk_buf[last_idx] <= fill_word;
          if (marker_next && !marker_pending) begin
            blk_buf[last_idx + 4'd1] <= marker_word();
          end
          if (fits_len) begin
            blk_buf[14] <= bit_len[63:32];
            blk_buf[15] <= bit_len[31:0];
            final_blk   <= 1'b1;
          end else begin
            final_blk   <= 1'b0;
            need_extra  <= 1'b1;
            pending_80  <= marker_pending;
          end
          sha_start <= 1'b1;
          new_msg_n <= ~first_blk;
          state     <= S_START;
        end

        S_START: begin
          idx       <= '0;
          first_blk <= 1'b0;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (word_valid) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (hash_done) begin
            if (final_blk) begin
              msg_done <= 1'b1;
              state    <= S_DONE;
            end else if (need_extra) begin
              // Overflow block: zeros, optional marker, then length.
              for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
              blk_buf[0]  <= pending_80 ? marker_word() : 32'h0000_0000;
              blk_buf[14] <= bit_len[63:32];
              blk_buf[15] <= bit_len[31:0];
              final_blk   <= 1'b1;
              need_extra  <= 1'b0;
              pending_80  <= 1'b0;
              sha_start   <= 1'b1;
              new_msg_n   <= ~first_blk;
              state       <= S_START;
            end else begin
              idx   <= '0;
              state <= S_LOAD;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
